// File: rtl/hud_bar_render.sv
// hud_bar_render: bordered N-segment HUD bar with per-frame latched level, low-level
// blink and registered pixel output. Define HUD_GHOST_EN to add the draining damage ghost trail.
module hud_bar_render #(
  parameter int          X0           = 120,
  parameter int          Y0           = 52,
  parameter int          SEG_W        = 20,
  parameter int          SEG_NUM      = 9,
  parameter int          BAR_H        = 16,
  parameter int          VAL_W        = 5,
  parameter int          LOW_TH       = 2,
  parameter int          BLINK_FRAMES = 15,
  parameter int          GHOST_FRAMES = 4,
  parameter logic [11:0] FILL_COLOR   = 12'hF00
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             frame_tick,
  input  logic [VAL_W-1:0] value,
  input  logic [10:0]      VGA_xpos,
  input  logic [10:0]      VGA_ypos,
  output logic [11:0]      VGA_data,
  output logic             pixel_hit
);

  localparam int LVL_W = $clog2(SEG_NUM + 1);
  localparam int BC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [10:0]      X0_L      = 11'(X0);
  localparam logic [10:0]      X1_L      = 11'(X0 + SEG_NUM * SEG_W);
  localparam logic [10:0]      Y0_L      = 11'(Y0);
  localparam logic [10:0]      Y1_L      = 11'(Y0 + BAR_H);
  localparam logic [10:0]      SEG_W_L   = 11'(SEG_W);
  localparam logic [31:0]      SEG_NUM_U = 32'(SEG_NUM);
  localparam logic [31:0]      LOW_TH_U  = 32'(LOW_TH);
  localparam logic [LVL_W-1:0] SEG_NUM_L = LVL_W'(SEG_NUM);
  localparam logic [BC_W-1:0]  BC_LAST   = BC_W'(BLINK_FRAMES - 1);

  if (SEG_W < 2 || SEG_NUM < 1 || BLINK_FRAMES < 1 || GHOST_FRAMES < 1) begin : g_cfg_err
    $error("hud_bar_render: invalid geometry or frame-count parameters");
  end

  logic [LVL_W-1:0] r_level;
  logic [BC_W-1:0]  r_bcnt;
  logic             r_bphase;
  logic [LVL_W-1:0] w_tgt;
  logic [LVL_W-1:0] w_ghost;
  logic             w_upd;

  assign w_tgt = (32'(value) > SEG_NUM_U) ? SEG_NUM_L : LVL_W'(value);
  assign w_upd = frame_tick & enable;

  // Frame-rate state: level and blink phase only move on an enabled frame tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level  <= '0;
      r_bcnt   <= '0;
      r_bphase <= 1'b0;
    end else if (w_upd) begin
      r_level <= w_tgt;
      if (r_bcnt == BC_LAST) begin
        r_bcnt   <= '0;
        r_bphase <= ~r_bphase;
      end else begin
        r_bcnt <= r_bcnt + 1'b1;
      end
    end
  end

`ifdef HUD_GHOST_EN
  localparam int              GC_W    = (GHOST_FRAMES > 1) ? $clog2(GHOST_FRAMES) : 1;
  localparam logic [GC_W-1:0] GC_LAST = GC_W'(GHOST_FRAMES - 1);

  logic [LVL_W-1:0] r_ghost;
  logic [GC_W-1:0]  r_gcnt;

  // A drop freezes the ghost at the old level; it then drains one segment per GHOST_FRAMES ticks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ghost <= '0;
      r_gcnt  <= '0;
    end else if (w_upd) begin
      if (w_tgt < r_level) begin
        r_gcnt <= '0;
      end else if (r_ghost <= w_tgt) begin
        r_ghost <= w_tgt;
        r_gcnt  <= '0;
      end else if (r_gcnt == GC_LAST) begin
        r_ghost <= r_ghost - 1'b1;
        r_gcnt  <= '0;
      end else begin
        r_gcnt <= r_gcnt + 1'b1;
      end
    end
  end

  assign w_ghost = r_ghost;
`else
  assign w_ghost = r_level;
`endif

  logic [10:0] w_xr;
  logic [10:0] w_fill_end;
  logic [10:0] w_ghost_end;
  logic        w_in_box;
  logic        w_border;
  logic        w_div;
  logic        w_blink;
  logic [11:0] w_data;
  logic        w_hit;

  assign w_xr        = VGA_xpos - X0_L;
  assign w_fill_end  = 11'(r_level) * SEG_W_L;
  assign w_ghost_end = 11'(w_ghost) * SEG_W_L;
  assign w_in_box    = (VGA_xpos >= X0_L) && (VGA_xpos <= X1_L) &&
                       (VGA_ypos >= Y0_L) && (VGA_ypos <= Y1_L);
  assign w_border    = (VGA_xpos == X0_L) || (VGA_xpos == X1_L) ||
                       (VGA_ypos == Y0_L) || (VGA_ypos == Y1_L);
  assign w_blink     = (r_level != '0) && (32'(r_level) <= LOW_TH_U);

  always_comb begin
    w_div = 1'b0;
    for (int k = 1; k < SEG_NUM; k++) begin
      if (w_xr == 11'(k * SEG_W)) w_div = 1'b1;
    end
  end

  // Classification order matters: border, divider, fill, ghost, empty interior
  always_comb begin
    w_data = 12'h000;
    w_hit  = 1'b0;
    if (w_in_box) begin
      w_hit = 1'b1;
      if (w_border) begin
        w_data = 12'hF00;
      end else if (w_div) begin
        w_data = 12'h000;
      end else if (w_xr < w_fill_end) begin
        w_data = (w_blink && r_bphase) ? 12'hFFF : FILL_COLOR;
      end else if (w_xr < w_ghost_end) begin
        w_data = 12'hFF0;
      end
    end
  end

  // Output register stage: one clock of latency, blanked while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      VGA_data  <= 12'h000;
      pixel_hit <= 1'b0;
    end else if (enable) begin
      VGA_data  <= w_data;
      pixel_hit <= w_hit;
    end else begin
      VGA_data  <= 12'h000;
      pixel_hit <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hud_bar_render.sv
// Self-checking bench for hud_bar_render: vector table, hand-written multi-frame sequences
// and randomized traffic against a frame-level behavioural model.
module tb_hud_bar_render;

  localparam int X0 = 120, Y0 = 52, SEG_W = 20, SEG_NUM = 9, BAR_H = 16, VAL_W = 5;
  localparam int LOW_TH = 2, BLINK_FRAMES = 15, GHOST_FRAMES = 4;
`ifdef HUD_GHOST_EN
  localparam bit GHOST_EN = 1'b1;
`else
  localparam bit GHOST_EN = 1'b0;
`endif
  localparam logic [11:0] YEL = GHOST_EN ? 12'hFF0 : 12'h000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b1;
  logic             frame_tick = 1'b0;
  logic [VAL_W-1:0] value = '0;
  logic [10:0]      VGA_xpos = '0;
  logic [10:0]      VGA_ypos = '0;
  logic [11:0]      VGA_data;
  logic             pixel_hit;

  always #5 clk = ~clk;

  hud_bar_render #(
    .X0(X0), .Y0(Y0), .SEG_W(SEG_W), .SEG_NUM(SEG_NUM), .BAR_H(BAR_H), .VAL_W(VAL_W),
    .LOW_TH(LOW_TH), .BLINK_FRAMES(BLINK_FRAMES), .GHOST_FRAMES(GHOST_FRAMES),
    .FILL_COLOR(12'hF00)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .frame_tick(frame_tick), .value(value),
    .VGA_xpos(VGA_xpos), .VGA_ypos(VGA_ypos), .VGA_data(VGA_data), .pixel_hit(pixel_hit)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Frame-level model state
  int m_level = 0, m_ghost = 0, m_gcnt = 0, m_bcnt = 0;
  bit m_bphase = 1'b0;

  task automatic m_reset();
    m_level = 0; m_ghost = 0; m_gcnt = 0; m_bcnt = 0; m_bphase = 1'b0;
  endtask

  task automatic m_tick(input int v);
    int t;
    t = (v > SEG_NUM) ? SEG_NUM : v;
    if (t < m_level) m_gcnt = 0;
    else if (m_ghost <= t) begin m_ghost = t; m_gcnt = 0; end
    else begin
      m_gcnt++;
      if (m_gcnt == GHOST_FRAMES) begin m_gcnt = 0; m_ghost--; end
    end
    m_level = t;
    if (!GHOST_EN) m_ghost = m_level;
    m_bcnt++;
    if (m_bcnt == BLINK_FRAMES) begin m_bcnt = 0; m_bphase = !m_bphase; end
  endtask

  function automatic logic [12:0] m_pix(input int x, input int y);
    int x1, y1, xr;
    bit blink;
    x1 = X0 + SEG_NUM * SEG_W;
    y1 = Y0 + BAR_H;
    if (!enable) return 13'h0;
    if (x < X0 || x > x1 || y < Y0 || y > y1) return 13'h0;
    if (x == X0 || x == x1 || y == Y0 || y == y1) return {1'b1, 12'hF00};
    xr = x - X0;
    if (xr % SEG_W == 0) return {1'b1, 12'h000};
    blink = (m_level >= 1) && (m_level <= LOW_TH);
    if (xr < m_level * SEG_W) return {1'b1, (blink && m_bphase) ? 12'hFFF : 12'hF00};
    if (xr < m_ghost * SEG_W) return {1'b1, 12'hFF0};
    return {1'b1, 12'h000};
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic tick(input int v);
    @(negedge clk);
    value = VAL_W'(v);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    if (enable) m_tick(v);
  endtask

  task automatic pix(input string name, input int x, input int y, output logic [11:0] got);
    logic [12:0] e;
    @(negedge clk);
    VGA_xpos = 11'(x);
    VGA_ypos = 11'(y);
    e = m_pix(x, y);
    @(posedge clk);
    #1;
    check({name, " hit(model)"}, int'(pixel_hit), int'(e[12]));
    check({name, " data(model)"}, int'(VGA_data), int'(e[11:0]));
    got = VGA_data;
  endtask

  task automatic pix_const(input string name, input int x, input int y,
                           input logic [11:0] data, input logic hit);
    logic [11:0] got;
    pix(name, x, y, got);
    check({name, " data"}, int'(got), int'(data));
    check({name, " hit"}, int'(pixel_hit), int'(hit));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
  endtask

  typedef struct {
    int          val;
    int          ticks;
    int          x;
    int          y;
    logic [11:0] data;
    logic        hit;
  } vec_t;

  vec_t vt[13];

  initial begin
    logic [11:0] got;
    int          yellow;

    vt[0]  = '{0,  0, 130, 60, 12'h000, 1'b1};
    vt[1]  = '{9,  1, 130, 60, 12'hF00, 1'b1};
    vt[2]  = '{9,  0, 300, 60, 12'hF00, 1'b1};
    vt[3]  = '{9,  0, 140, 60, 12'h000, 1'b1};
    vt[4]  = '{9,  0, 119, 60, 12'h000, 1'b0};
    vt[5]  = '{9,  0, 120, 52, 12'hF00, 1'b1};
    vt[6]  = '{9,  0, 210, 68, 12'hF00, 1'b1};
    vt[7]  = '{9,  0, 301, 60, 12'h000, 1'b0};
    vt[8]  = '{9,  0, 210, 69, 12'h000, 1'b0};
    vt[9]  = '{31, 1, 295, 60, 12'hF00, 1'b1};
    vt[10] = '{31, 0, 280, 60, 12'h000, 1'b1};
    vt[11] = '{31, 0, 299, 67, 12'hF00, 1'b1};
    vt[12] = '{31, 0, 210, 51, 12'h000, 1'b0};

    #12;
    check("reset data", int'(VGA_data), 0);
    check("reset hit", int'(pixel_hit), 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();

    for (int i = 0; i < 13; i++) begin
      for (int t = 0; t < vt[i].ticks; t++) tick(vt[i].val);
      pix_const($sformatf("vec%0d", i), vt[i].x, vt[i].y, vt[i].data, vt[i].hit);
    end

    // Damage ghost drain
    do_reset();
    tick(9);
    tick(5);
    pix_const("ghost start x230", 230, 60, YEL, 1'b1);
    repeat (4) tick(5);
    pix_const("ghost 8 x221", 221, 60, YEL, 1'b1);
    repeat (12) tick(5);
    pix_const("ghost drained x230", 230, 60, 12'h000, 1'b1);

    // Low-level blink, freeze while disabled
    do_reset();
    tick(2);
    pix_const("blink t1", 125, 60, 12'hF00, 1'b1);
    repeat (13) tick(2);
    pix_const("blink t14", 125, 60, 12'hF00, 1'b1);
    tick(2);
    pix_const("blink t15", 125, 60, 12'hFFF, 1'b1);
    repeat (14) tick(2);
    pix_const("blink t29", 125, 60, 12'hFFF, 1'b1);
    tick(2);
    pix_const("blink t30", 125, 60, 12'hF00, 1'b1);
    repeat (5) tick(2);
    @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(2);
      pix_const($sformatf("disabled %0d", i), 125, 60, 12'h000, 1'b0);
    end
    @(negedge clk);
    enable = 1'b1;
    repeat (9) tick(2);
    pix_const("reenable t44", 125, 60, 12'hF00, 1'b1);
    tick(2);
    pix_const("reenable t45", 125, 60, 12'hFFF, 1'b1);
    tick(3);
    pix_const("level3 steady", 125, 60, 12'hF00, 1'b1);
    tick(0);
    pix_const("level0 empty", 125, 60, 12'h000, 1'b1);

    // Asynchronous reset in the middle of a drain
    do_reset();
    tick(9);
    tick(5);
    repeat (8) tick(5);
    @(negedge clk);
    VGA_xpos = 11'd230;
    VGA_ypos = 11'd60;
    @(posedge clk);
    #1;
    check("pre-reset hit", int'(pixel_hit), 1);
    check("pre-reset data", int'(VGA_data), int'(YEL));
    #2 rst_n = 1'b0;
    #1;
    check("async reset data", int'(VGA_data), 0);
    check("async reset hit", int'(pixel_hit), 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    tick(5);
    yellow = 0;
    for (int x = 121; x < 300; x++) begin
      pix($sformatf("post-reset x%0d", x), x, 60, got);
      if (got == 12'hFF0) yellow++;
    end
    check("yellow after reset", yellow, 0);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 3) begin
        tick($urandom_range(0, 31));
      end else if (r == 3) begin
        @(negedge clk);
        enable = ($urandom_range(0, 3) != 0);
      end else begin
        pix($sformatf("rand%0d", i), $urandom_range(115, 305), $urandom_range(48, 72), got);
      end
    end
    enable = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hud_bar_render.md
# hud_bar_render

Parametrised segmented status-bar renderer for the game HUD: draws a bordered, N-segment bar (HP or time) at a configurable screen position into the VGA pixel stream. Unlike the fixed-geometry predecessor it latches the displayed level once per frame, animates damage with a draining "ghost" trail, blinks when the level is low, and registers its pixel output. It sits beside the other overlay generators, and its `VGA_data`/`pixel_hit` pair feeds the screen mux.

## Interface
- `X0`, default 120: left border x.
- `Y0`, default 52: top border y.
- `SEG_W`, default 20: segment width in pixels, ≥2.
- `SEG_NUM`, default 9: segment count, ≥1; `X0+SEG_NUM*SEG_W` ≤ 2047.
- `BAR_H`, default 16: bottom border is at `Y0+BAR_H`.
- `VAL_W`, default 5: width of `value`.
- `LOW_TH`, default 2: blink when 1 ≤ level ≤ `LOW_TH`.
- `BLINK_FRAMES`, default 15: frame ticks per blink half-period, ≥1.
- `GHOST_FRAMES`, default 4: frame ticks per ghost decrement step, ≥1.
- `FILL_COLOR`, default 12'hF00: fill colour.
- `clk`, in, 1: pixel/system clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: bar visible and state machine running.
- `frame_tick`, in, 1: one-cycle pulse per frame, at start of vertical blank.
- `value`, in, VAL_W: target level in segments.
- `VGA_xpos`, in, 11: current pixel x.
- `VGA_ypos`, in, 11: current pixel y.
- `VGA_data`, out, 12: RGB444 pixel.
- `pixel_hit`, out, 1: the bar owns this pixel.

## Operation
- Clamp: `tgt = min(value, SEG_NUM)`.
- `level` and `ghost` (0..SEG_NUM) update only on a cycle with `frame_tick & enable`. This prevents mid-frame tearing.
- On each update:
  - `tgt > ghost` or `tgt ≥ level`: `level ← tgt`; if `ghost < tgt`, `ghost ← tgt`.
  - `tgt < level`: `level ← tgt`; `ghost` holds its value and `gcnt` clears.
- Ghost drain: while `ghost > level`, each update increments `gcnt`. When `gcnt` reaches `GHOST_FRAMES-1`: `gcnt ← 0` and `ghost ← ghost-1`. When `ghost == level`, `gcnt` holds 0.
- Blink: `bcnt` counts updates 0..`BLINK_FRAMES-1` and wraps. On wrap, `bphase` toggles. Blink is active when 1 ≤ `level` ≤ `LOW_TH`.
- Pixel classification, first match wins, with `xr = x - X0`:
  1. Border: x∈{X0, X0+SEG_NUM·SEG_W} with Y0≤y≤Y0+BAR_H, or y∈{Y0, Y0+BAR_H} with X0≤x≤X0+SEG_NUM·SEG_W → 12'hF00.
  2. Divider: strictly inside the bar and `xr` = k·SEG_W for k=1..SEG_NUM-1 → 12'h000.
  3. Fill: `xr < level·SEG_W` → `FILL_COLOR`, or 12'hFFF when blink is active and `bphase`=1.
  4. Ghost: `level·SEG_W ≤ xr < ghost·SEG_W` → 12'hFF0.
  5. Otherwise inside the bar → 12'h000.
  6. Outside the bar → `pixel_hit`=0, `VGA_data`=0.
- `enable`=0: `pixel_hit`=0, `VGA_data`=0, and all state (`level`, `ghost`, `gcnt`, `bcnt`, `bphase`) frozen.
- Arithmetic: products and compares are computed at 11 bits unsigned; there are no subtractions below X0 outside the bar.

## Timing
- Output latency: one clock. Outputs for (x,y) presented in cycle n are registered at the edge ending cycle n.
- A `value` change becomes visible from the first pixel after the next `frame_tick`.
- `frame_tick` and a pixel inside the bar in the same cycle: that pixel uses the pre-update state.
- Reset (asynchronous, at any time including mid-frame or mid-drain): `level`=0, `ghost`=0, `gcnt`=0, `bcnt`=0, `bphase`=0, `VGA_data`=12'h000, `pixel_hit`=0. The first update after reset loads `level`=`ghost`=`tgt` with no ghost.

## Configuration
- `HUD_GHOST_EN` defined:
  - Ghost register, `gcnt`, drain logic and the yellow ghost region are present.
- `HUD_GHOST_EN` undefined:
  - `ghost` is tied to `level` and `gcnt` is removed.
  - A decrease shows no yellow region; class 4 never matches.
  - All other behaviour is identical.

## Test plan
- Reset, then `value`=9, one `frame_tick`, then scan (130,60) and (300,60):
  - Fill F00 at (130,60).
  - Border F00 at (300,60).
  - (140,60) is divider 000.
  - `pixel_hit`=1 one cycle after each pixel.
- With `HUD_GHOST_EN`, level 9, then `value`=5 and `frame_tick`:
  - x=230: yellow FF0.
  - x=221 after 4 more ticks: ghost=8, still yellow at x=221 (ghost range 220..279).
  - After 16 ticks total: ghost=5, x=230 is 000.
- `value`=2:
  - (125,60) alternates F00/FFF, switching every 15 ticks.
  - `value`=3 → steady F00.
  - `value`=0 → no fill, no blink.
- `value`=31 (above SEG_NUM) → same image as `value`=9.
- `rst_n` pulled low mid-drain (ghost=7, level=5), asynchronously, outside a clock edge:
  - Outputs 0 immediately.
  - After release and `value`=5 with a tick: no yellow anywhere.
- `enable`=0 for 20 ticks during blink:
  - `pixel_hit`=0 throughout.
  - On re-enable, `bphase` and `bcnt` are unchanged from their pre-disable values.
